jtframe_mixer_seq: RTL
======================

# jtframe_mixer_seq

Time-multiplexed, parametrised audio mixer for JTFRAME sound paths. It sums CH signed channels, each scaled by its own 4.4 fixed-point gain, using a single shared multiplier stepped one channel per clock-enable. The result is saturated to the output range and presented with a one-clock valid strobe. The block sits between the sound chips and the frame audio output. It also reports sticky clip and overrun flags and a resettable peak-level meter.

## Interface
- CH, 4: number of channels, 2..8
- WIN, 16: width of every input channel (signed), 8..16
- WOUT, 16: output width (signed), 8..16
- clk  in  1  system clock
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- cen  in  1  clock enable; all sequencing advances only on clk edges with cen=1
- sample  in  1  start-of-mix request, sampled on cen edges
- ch  in  CH*WIN  packed signed channels, channel k at [k*WIN +: WIN]
- gain  in  CH*8  packed unsigned 4.4 gains, channel k at [k*8 +: 8]
- flag_clr  in  1  clears clip and overrun (any clk edge)
- peak_clr  in  1  clears peak (any clk edge)
- mixed  out  WOUT  signed mixed sample
- valid  out  1  one-clk pulse when mixed updates
- busy  out  1  mix in progress
- clip  out  1  sticky: saturation occurred
- overrun  out  1  sticky: sample arrived while busy
- peak  out  WOUT-1  max |mixed| since last clear

## Operation
- States: IDLE, ACC, SAT.
- IDLE: on a cen edge with sample=1:
  - snapshot all of ch and gain into internal registers; later input changes do not affect this mix
  - acc=0, idx=0, busy=1, go to ACC
- ACC: each cen edge adds prod = ch[idx] * {1'b0, gain[idx]} (signed, WIN+9 bits, sign-extended) to acc.
  - After idx=CH-1, go to SAT.
  - Accumulator width: WIN+9+ceil(log2 CH) bits; it never overflows.
- SAT: on the cen edge:
  - r = acc >>> 4 (arithmetic shift, floor rounding)
  - saturate r to [-2^(WIN-1), 2^(WIN-1)-1]
  - set clip when a limit is applied
  - mixed = top WOUT bits of the WIN-bit result when WOUT≤WIN; otherwise the result left-shifted by WOUT-WIN with zero fill
  - valid=1, busy=0, go to IDLE
  - peak = max(peak, |mixed|); |−2^(WOUT-1)| is treated as 2^(WOUT-1)-1
- sample=1 on a cen edge while busy=1 (ACC or SAT, including the SAT edge itself):
  - the request is ignored and overrun is set
  - the current mix completes unaffected
- Flag priority: on the same edge, set wins over flag_clr for clip and overrun; a new peak value wins over peak_clr.
- gain=0 fully mutes a channel; 0x10 is unity; 0xFF is ×15.9375.

## Timing
- Reset (asynchronous, rst_n=0) values:
  - mixed=0, valid=0, busy=0, clip=0, overrun=0, peak=0
  - internal idx=0, acc=0, state=IDLE
- Reset mid-mix aborts the mix with no valid.
- Latency: sample accepted at cen edge E0; accumulation on E1..ECH; mixed, valid and peak update at ECH+1.
  - With cen tied high, this is CH+1 clocks.
- busy rises after E0 and falls after ECH+1. The next sample is accepted no earlier than ECH+2.
- valid is high for exactly one clk cycle regardless of cen. mixed holds its value until the next SAT.
- The clear inputs act on any clk edge and are not gated by cen.
- cen low stalls the sequencer with all state held.

## Test plan
- CH=4, WIN=WOUT=16, cen=1; ch0=1000, gain0=0x10, other gains 0; pulse sample -> valid exactly 5 clks later, mixed=1000, clip=0, peak=1000.
- All four channels 0x4000, all gains 0x10 -> sum 0x10000 saturates: mixed=0x7FFF, clip=1, peak=0x7FFF; flag_clr then clears clip.
- ch0=-20000, gain0=0x20, others muted -> mixed=0x8000 (-32768), clip=1, peak=0x7FFF.
- Fractional gain 0x08: ch0=1001 -> mixed=500; ch0=-1001 -> mixed=-501 (floor).
- Second sample 2 clks after the first, plus ch changed mid-mix -> first result reflects the snapshot, overrun=1, only one valid; sample with cen toggling 1-of-3 -> same result, latency 5 cen edges.
- rst_n low during ACC -> all outputs 0 immediately, no valid after release until a new sample; WOUT=12 run of the first scenario -> mixed=62 (1000>>4).

Source files
------------

// File: rtl/jtframe_mixer_seq.sv
// Time-multiplexed audio mixer: one shared multiplier walks the snapshotted
// channels, then the sum is saturated, scaled to the output width and metered.
module jtframe_mixer_seq #(
    parameter int CH   = 4,
    parameter int WIN  = 16,
    parameter int WOUT = 16
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    cen,
    input  logic                    sample,
    input  logic [CH*WIN-1:0]       ch,
    input  logic [CH*8-1:0]         gain,
    input  logic                    flag_clr,
    input  logic                    peak_clr,
    output logic signed [WOUT-1:0]  mixed,
    output logic                    valid,
    output logic                    busy,
    output logic                    clip,
    output logic                    overrun,
    output logic [WOUT-2:0]         peak
);

    localparam int IW = $clog2(CH);
    localparam int PW = WIN + 9;
    localparam int AW = PW + IW;

    localparam logic signed [AW-1:0] SMAX = {{(AW-WIN+1){1'b0}}, {(WIN-1){1'b1}}};
    localparam logic signed [AW-1:0] SMIN = {{(AW-WIN+1){1'b1}}, {(WIN-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, ACC, SAT} state_t;

    state_t                 state;
    logic [IW-1:0]          idx;
    logic signed [AW-1:0]   acc;
    logic [CH*WIN-1:0]      ch_q;
    logic [CH*8-1:0]        gain_q;

    logic [WIN-1:0]         cur_ch;
    logic [7:0]             cur_gain;
    logic signed [PW-1:0]   ch_ext;
    logic signed [PW-1:0]   gain_ext;
    logic signed [PW-1:0]   prod;
    logic signed [AW-1:0]   prod_ext;

    logic signed [AW-1:0]   r;
    logic                   sat_hi;
    logic                   sat_lo;
    logic signed [WIN-1:0]  sat_val;
    logic signed [WOUT-1:0] mixed_n;
    logic [WOUT-1:0]        neg;
    logic [WOUT-2:0]        mag;
    logic [WOUT-2:0]        peak_base;

    // Channel/gain selection for the current step of the walk
    always_comb begin
        cur_ch   = '0;
        cur_gain = '0;
        for (int k = 0; k < CH; k++) begin
            if (idx == IW'(k)) begin
                cur_ch   = ch_q[k*WIN +: WIN];
                cur_gain = gain_q[k*8 +: 8];
            end
        end
    end

    // Gain is unsigned, so it gets a zero sign bit before the signed multiply;
    // |ch|*255 always fits in WIN+9 bits, so truncating the product is exact.
    assign ch_ext   = {{9{cur_ch[WIN-1]}}, cur_ch};
    assign gain_ext = {{WIN{1'b0}}, 1'b0, cur_gain};
    assign prod     = ch_ext * gain_ext;
    assign prod_ext = {{IW{prod[PW-1]}}, prod};

    assign r      = acc >>> 4;
    assign sat_hi = r > SMAX;
    assign sat_lo = r < SMIN;

    always_comb begin
        if (sat_hi)
            sat_val = {1'b0, {(WIN-1){1'b1}}};
        else if (sat_lo)
            sat_val = {1'b1, {(WIN-1){1'b0}}};
        else
            sat_val = r[WIN-1:0];
    end

    generate
        if (WOUT <= WIN) begin : g_narrow
            assign mixed_n = sat_val[WIN-1 -: WOUT];
        end else begin : g_wide
            assign mixed_n = {sat_val, {(WOUT-WIN){1'b0}}};
        end
    endgenerate

    // The most negative code has no positive twin; it reads as full scale.
    assign neg = -mixed_n;

    always_comb begin
        if (!mixed_n[WOUT-1])
            mag = mixed_n[WOUT-2:0];
        else if (mixed_n[WOUT-2:0] == '0)
            mag = '1;
        else
            mag = neg[WOUT-2:0];
    end

    assign peak_base = peak_clr ? '0 : peak;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            idx     <= '0;
            acc     <= '0;
            ch_q    <= '0;
            gain_q  <= '0;
            mixed   <= '0;
            valid   <= 1'b0;
            busy    <= 1'b0;
            clip    <= 1'b0;
            overrun <= 1'b0;
            peak    <= '0;
        end else begin
            valid <= 1'b0;
            if (flag_clr) begin
                clip    <= 1'b0;
                overrun <= 1'b0;
            end
            if (peak_clr)
                peak <= '0;
            // Set assignments below come later, so they win over the clears
            if (cen) begin
                case (state)
                    IDLE: begin
                        if (sample) begin
                            ch_q   <= ch;
                            gain_q <= gain;
                            acc    <= '0;
                            idx    <= '0;
                            busy   <= 1'b1;
                            state  <= ACC;
                        end
                    end
                    ACC: begin
                        if (sample)
                            overrun <= 1'b1;
                        acc <= acc + prod_ext;
                        if (idx == IW'(CH-1)) begin
                            idx   <= '0;
                            state <= SAT;
                        end else begin
                            idx <= idx + 1'b1;
                        end
                    end
                    SAT: begin
                        if (sample)
                            overrun <= 1'b1;
                        if (sat_hi || sat_lo)
                            clip <= 1'b1;
                        if (mag > peak_base)
                            peak <= mag;
                        mixed <= mixed_n;
                        valid <= 1'b1;
                        busy  <= 1'b0;
                        state <= IDLE;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
